or2_gate: RTL and testbench



---
 rtl/or2_gate_pkg.sv | 15 +
 rtl/or2_gate_core.sv | 13 +
 rtl/or2_gate.sv | 50 +++++
 tb/tb_or2_gate.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/or2_gate_pkg.sv
// Shared helpers for the or2_gate block.
// Defaults and the edge-detect term used by the register stage.
package or2_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  function automatic logic rise_of(
    input logic cur,
    input logic prev
  );
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/or2_gate_core.sv
// Purely combinational bitwise OR.
// No clock or reset; usable as a bare logic primitive.
module or2_gate_core #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F
);

  assign F = A | B;

endmodule

// File: rtl/or2_gate.sv
// Two-input OR with a registered copy, rise pulse and
// saturating assertion counter.
module or2_gate
  import or2_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] F_q,
  output logic             F_rise,
  output logic [CNT_W-1:0] F_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic any_f;
  logic any_q;

  or2_gate_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .A(A),
    .B(B),
    .F(F)
  );

  assign any_f = |F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q     <= '0;
      any_q   <= 1'b0;
      F_rise  <= 1'b0;
      F_count <= '0;
    end else begin
      F_q    <= F;
      any_q  <= any_f;
      F_rise <= rise_of(any_f, any_q);
      // hold at all-ones rather than wrap
      if (any_f && (F_count != CNT_MAX))
        F_count <= F_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_or2_gate.sv
// Self-checking bench for or2_gate: directed and random
// stimulus against a cycle-level reference model.
module tb_or2_gate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [3:0] aw = '0;
  logic [3:0] bw = '0;

  logic       f, fq, fr;
  logic [7:0] fc;
  logic       fs, fqs, frs;
  logic [1:0] fcs;
  logic [3:0] fw, fqw;
  logic       frw;
  logic [7:0] fcw;

  int checks = 0;
  int errors = 0;

  int   cnt8, cnt2, cntw;
  bit   prev1, prevw;
  logic exp_q1, exp_r1, exp_rw;
  logic [3:0] exp_qw;

  or2_gate #(.WIDTH(1), .CNT_W(8)) u_def (
    .A(a), .B(b), .F(f), .clk(clk), .rst_n(rst_n),
    .F_q(fq), .F_rise(fr), .F_count(fc)
  );

  or2_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
    .A(a), .B(b), .F(fs), .clk(clk), .rst_n(rst_n),
    .F_q(fqs), .F_rise(frs), .F_count(fcs)
  );

  or2_gate #(.WIDTH(4), .CNT_W(8)) u_wide (
    .A(aw), .B(bw), .F(fw), .clk(clk), .rst_n(rst_n),
    .F_q(fqw), .F_rise(frw), .F_count(fcw)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cnt8 = 0; cnt2 = 0; cntw = 0;
    prev1 = 0; prevw = 0;
    exp_q1 = 0; exp_r1 = 0;
    exp_qw = '0; exp_rw = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".fq"}, 32'(fq), 32'(exp_q1));
    check({tag, ".fr"}, 32'(fr), 32'(exp_r1));
    check({tag, ".fc"}, 32'(fc), 32'(cnt8));
    check({tag, ".fqs"}, 32'(fqs), 32'(exp_q1));
    check({tag, ".frs"}, 32'(frs), 32'(exp_r1));
    check({tag, ".fcs"}, 32'(fcs), 32'(cnt2));
    check({tag, ".fqw"}, 32'(fqw), 32'(exp_qw));
    check({tag, ".frw"}, 32'(frw), 32'(exp_rw));
    check({tag, ".fcw"}, 32'(fcw), 32'(cntw));
  endtask

  // called just after a falling edge; ends just after the next one
  task automatic step(
    input string      tag,
    input logic       ai,
    input logic       bi,
    input logic [3:0] awi,
    input logic [3:0] bwi
  );
    bit any1, anyw;
    a = ai; b = bi; aw = awi; bw = bwi;
    #1;
    check({tag, ".f"}, 32'(f), 32'(ai | bi));
    check({tag, ".fw"}, 32'(fw), 32'(awi | bwi));
    @(posedge clk);
    any1 = (ai || bi);
    anyw = ((awi | bwi) != 4'd0);
    exp_q1 = any1;
    exp_r1 = any1 && !prev1;
    prev1 = any1;
    if (any1) begin
      cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
      cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
    end
    exp_qw = awi | bwi;
    exp_rw = anyw && !prevw;
    prevw = anyw;
    if (anyw) cntw = (cntw < 255) ? cntw + 1 : 255;
    @(negedge clk);
    check_regs(tag);
  endtask

  initial begin
    model_reset();

    // truth table, reset held, no edges relied on
    a = 0; b = 0; #1; check("tt00", 32'(f), 32'd0);
    a = 0; b = 1; #1; check("tt01", 32'(f), 32'd1);
    a = 1; b = 0; #1; check("tt10", 32'(f), 32'd1);
    a = 1; b = 1; #1; check("tt11", 32'(f), 32'd1);
    a = 0; b = 1'bx; #1; check("tt0x", 32'(f), 32'(1'bx));
    a = 1; b = 1'bx; #1; check("tt1x", 32'(f), 32'd1);
    b = 0;
    aw = 4'b1010; bw = 4'b0101; #1;
    check("wide_ones", 32'(fw), 32'hf);
    aw = 4'b0000; bw = 4'b0000; #1;
    check("wide_zero", 32'(fw), 32'h0);

    // reset held with A=1 and clock running
    a = 1; b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.f", 32'(f), 32'd1);
    check_regs("rst");

    // release with F=1: first edge must pulse
    rst_n = 1'b1;
    step("rel", 1, 0, 4'h1, 4'h0);

    step("low0", 0, 0, 4'h0, 4'h0);
    step("low1", 0, 0, 4'h0, 4'h0);
    step("one", 1, 0, 4'h8, 4'h0);
    step("drop0", 0, 0, 4'h0, 4'h0);
    step("drop1", 0, 0, 4'h0, 4'h0);

    for (int i = 0; i < 5; i++)
      step("held", 1, 1, 4'h3, 4'hc);
    step("held_end", 0, 0, 4'h0, 4'h0);

    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom));

    // asynchronous reset between edges clears immediately
    a = 1; aw = 4'hf;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q1 = 0;
    check("arst.f", 32'(f), 32'd1);
    check_regs("arst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      step("rand2", 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
